fa4_sweep_checker: RTL and testbench
====================================

# fa4_sweep_checker

Self-checking stimulus engine that sits directly upstream of the 4-bit full adder (ripple or lookahead variant). It drives every combination of A, B and Cin into the adder, samples S and Cout after a programmable settle time, and compares them with an internal golden sum. It reports pass/fail, an error count and the first failing vector. It is used for on-board (FPGA) self-test of the adder, and all 512 vectors are covered.

## Interface
- SETTLE_CYCLES, 1, cycles operands are held before sampling; legal range 1..15.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE or DONE.
- s_i  in  4  sum returned by the adder under test.
- cout_i  in  1  carry-out returned by the adder under test.
- a_o  out  4  operand A to the adder.
- b_o  out  4  operand B to the adder.
- cin_o  out  1  carry-in to the adder.
- busy  out  1  high while a sweep is in progress (SETTLE or SAMPLE).
- done  out  1  high in DONE; held until restart or reset.
- pass  out  1  valid when done=1; equals (err_count == 0).
- err_count  out  10  number of mismatching vectors in the current or last sweep (0..512).
- first_fail  out  9  {A,B,Cin} of the first mismatching vector.
- first_fail_valid  out  1  set when first_fail holds a captured vector.

## Operation
- Vector index idx[8:0] = {A,B,Cin}, with Cin as the LSB.
  - a_o = idx[8:5], b_o = idx[4:1], cin_o = idx[0].
  - Order is A outer, B middle, Cin inner; it runs 0..511 with no vector skipped.
- Golden value: 5-bit zero-extended a_o + b_o + cin_o, compared against {cout_i, s_i}.
- State IDLE:
  - busy=0, done=0, idx=0.
  - start=1 → SETTLE. On that edge: idx←0, err_count←0, first_fail←0, first_fail_valid←0, settle counter←0.
- State SETTLE:
  - Operands are stable and the counter increments each cycle.
  - When counter == SETTLE_CYCLES-1 → SAMPLE.
- State SAMPLE (one cycle):
  - Comparison is performed on the s_i/cout_i present during this cycle.
  - On mismatch: err_count++. If first_fail_valid=0, then first_fail←idx and first_fail_valid←1.
  - If idx==511 → DONE; else idx++, counter←0, → SETTLE.
- State DONE:
  - done=1, busy=0, pass=(err_count==0).
  - Operands hold the last vector, and the results are held.
  - start=1 → SETTLE, with the same clears as in IDLE.
- start while busy is ignored; there is no restart and no abort.
- err_count cannot exceed 512 and needs no saturation.

## Timing
- Reset: state IDLE; a_o=0, b_o=0, cin_o=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0.
- Reset mid-sweep: on the next edge all outputs take their reset values and the sweep is discarded. Reset overrides start in the same cycle.
- All outputs are registered, and operands change only on the edge leaving SAMPLE.
- Per vector: SETTLE_CYCLES + 1 cycles.
  - busy rises on the edge that samples start=1.
  - done rises exactly 512×(SETTLE_CYCLES+1) edges later; busy falls on the same edge.
- With SETTLE_CYCLES=1, vector k is in SAMPLE during cycle 2k+1 after start acceptance, and done rises at edge 1024.
- An error on vector k is visible in err_count on the edge leaving that vector's SAMPLE cycle.
- The adder under test is combinational, and its path must settle within SETTLE_CYCLES clock periods.

## Test plan
- Correct adder model, SETTLE_CYCLES=1, start pulsed one cycle → done at edge 1024 after start, pass=1, err_count=0, first_fail_valid=0, and a_o/b_o/cin_o sequence through all 512 vectors in order.
- Adder with cout_i stuck at 0 → err_count=256, first_fail=9'h01F (A=0, B=15, Cin=1), pass=0.
- Adder with s_i[0] inverted only for A=9, B=6, Cin=0 → err_count=1, first_fail=9'd300, first_fail_valid=1.
- start held high through the entire sweep → single sweep, done at edge 1024, then an immediate restart: err_count, first_fail_valid and done clear on the restart edge.
- rst asserted while idx=100 → next edge: busy=0, all outputs zero, state IDLE. A subsequent start completes a full 1024-cycle sweep.
- SETTLE_CYCLES=3, correct adder → each operand held 4 cycles, done at edge 2048, pass=1.

Source files
------------

// File: rtl/fa4_sweep_checker.sv
// fa4_sweep_checker
// -----------------
// Self-test engine for a 4-bit combinational full adder. It walks every
// {A,B,Cin} combination (512 vectors, Cin fastest, A slowest). Each vector is
// held for SETTLE_CYCLES cycles and then sampled for one cycle. The adder's
// {cout_i, s_i} is compared with an internally computed golden sum.
//
// Parameters
//   SETTLE_CYCLES     cycles each vector is held before sampling (1..15)
//
// Ports
//   clk               system clock, rising-edge active
//   rst               synchronous active-high reset
//   start             level request to begin a sweep (taken in IDLE or DONE)
//   s_i, cout_i       sum / carry returned by the adder under test
//   a_o, b_o, cin_o   operands driven into the adder under test
//   busy              sweep in progress (SETTLE or SAMPLE)
//   done              sweep finished; held until restart or reset
//   pass              valid with done; high when no vector mismatched
//   err_count         mismatching vectors in the current or last sweep
//   first_fail        {A,B,Cin} of the first mismatching vector
//   first_fail_valid  first_fail holds a captured vector
//   state_dbg         current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//
// Handshake: start is a plain level. On any rising edge where the FSM is in
// IDLE or DONE and start=1, a new sweep begins. start is ignored while busy.
module fa4_sweep_checker #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] s_i,
   input  logic       cout_i,
   output logic [3:0] a_o,
   output logic [3:0] b_o,
   output logic       cin_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [9:0] err_count,
   output logic [8:0] first_fail,
   output logic       first_fail_valid,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q;
   state_t     state_d;
   logic [8:0] idx_q;
   logic [3:0] cnt_q;
   logic [4:0] golden;
   logic       mismatch;
   logic [9:0] err_next;

   // Operands come straight from the vector index register.
   assign a_o       = idx_q[8:5];
   assign b_o       = idx_q[4:1];
   assign cin_o     = idx_q[0];
   assign state_dbg = state_q;

   assign golden   = {1'b0, idx_q[8:5]} + {1'b0, idx_q[4:1]} + {4'b0000, idx_q[0]};
   assign mismatch = (state_q == SAMPLE) && ({cout_i, s_i} != golden);
   assign err_next = err_count + {9'd0, mismatch};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
         end
         SAMPLE: begin
            if (idx_q == 9'd511) state_d = DONE;
            else                 state_d = SETTLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         idx_q            <= 9'd0;
         cnt_q            <= 4'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= 10'd0;
         first_fail       <= 9'd0;
         first_fail_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         // Status flags are registered from the next state so they line up
         // with the state they describe.
         busy    <= (state_d == SETTLE) || (state_d == SAMPLE);
         done    <= (state_d == DONE);
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  idx_q            <= 9'd0;
                  cnt_q            <= 4'd0;
                  pass             <= 1'b0;
                  err_count        <= 10'd0;
                  first_fail       <= 9'd0;
                  first_fail_valid <= 1'b0;
               end
            end
            SETTLE: begin
               cnt_q <= cnt_q + 4'd1;
            end
            SAMPLE: begin
               err_count <= err_next;
               if (mismatch && !first_fail_valid) begin
                  first_fail       <= idx_q;
                  first_fail_valid <= 1'b1;
               end
               if (idx_q == 9'd511) begin
                  // Last vector: include its own result in the verdict.
                  pass <= (err_next == 10'd0);
               end else begin
                  idx_q <= idx_q + 9'd1;
                  cnt_q <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fa4_sweep_checker.sv
// Bench for fa4_sweep_checker. Two instances: SETTLE_CYCLES=1 and 3. Each
// drives a behavioural adder whose fault behaviour is selected by a mode.
module tb_fa4_sweep_checker;

   typedef struct packed {
      logic [8:0] vec;
      logic       busy;
      logic       done;
      logic       pass;
      logic [9:0] err;
      logic [8:0] ff;
      logic       ffv;
      logic [1:0] st;
   } obs_t;

   logic clk;
   logic rst;

   logic       start1, cout1, cin1, busy1, done1, pass1, ffv1;
   logic [3:0] s1, a1, b1;
   logic [9:0] err1;
   logic [8:0] ff1;
   logic [1:0] st1;

   logic       start3, cout3, cin3, busy3, done3, pass3, ffv3;
   logic [3:0] s3, a3, b3;
   logic [9:0] err3;
   logic [8:0] ff3;
   logic [1:0] st3;

   int mode1;
   int mode3;
   logic [4:0] rand_mask [512];

   int n_checks;
   int n_fail;

   fa4_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .s_i(s1), .cout_i(cout1),
      .a_o(a1), .b_o(b1), .cin_o(cin1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1), .first_fail(ff1),
      .first_fail_valid(ffv1), .state_dbg(st1)
   );

   fa4_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .s_i(s3), .cout_i(cout3),
      .a_o(a3), .b_o(b3), .cin_o(cin3), .busy(busy3), .done(done3),
      .pass(pass3), .err_count(err3), .first_fail(ff3),
      .first_fail_valid(ffv3), .state_dbg(st3)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [4:0] true_sum(input logic [8:0] v);
      int a, b, c;
      a = int'(v) / 32;
      b = (int'(v) / 2) % 16;
      c = int'(v) % 2;
      return 5'(a + b + c);
   endfunction

   // Behaviour of the adder under test for a given fault mode.
   function automatic logic [4:0] adder_model(input int mode, input logic [8:0] v);
      logic [4:0] t;
      t = true_sum(v);
      case (mode)
         1:       return {1'b0, t[3:0]};
         2:       return (v == 9'd300) ? (t ^ 5'd1) : t;
         3:       return t ^ rand_mask[v];
         default: return t;
      endcase
   endfunction

   // Adder outputs refresh mid-cycle, well inside the settle window.
   always @(negedge clk) begin
      {cout1, s1} <= adder_model(mode1, {a1, b1, cin1});
      {cout3, s3} <= adder_model(mode3, {a3, b3, cin3});
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic get_obs(input int which, output obs_t o);
      if (which == 1) o = '{vec: {a1, b1, cin1}, busy: busy1, done: done1, pass: pass1,
                            err: err1, ff: ff1, ffv: ffv1, st: st1};
      else            o = '{vec: {a3, b3, cin3}, busy: busy3, done: done3, pass: pass3,
                            err: err3, ff: ff3, ffv: ffv3, st: st3};
   endtask

   task automatic set_start(input int which, input logic val);
      if (which == 1) start1 = val;
      else            start3 = val;
   endtask

   task automatic check_reset_state(input int which, input string tag);
      obs_t o;
      get_obs(which, o);
      check_eq({tag, "_vec"},  32'(o.vec),  32'd0);
      check_eq({tag, "_busy"}, 32'(o.busy), 32'd0);
      check_eq({tag, "_done"}, 32'(o.done), 32'd0);
      check_eq({tag, "_pass"}, 32'(o.pass), 32'd0);
      check_eq({tag, "_err"},  32'(o.err),  32'd0);
      check_eq({tag, "_ff"},   32'(o.ff),   32'd0);
      check_eq({tag, "_ffv"},  32'(o.ffv),  32'd0);
      check_eq({tag, "_st"},   32'(o.st),   32'd0);
   endtask

   // Start a sweep on one instance and follow it edge by edge, comparing
   // against expectations derived from the vector order and the fault mode.
   // stop_at >= 0 returns right after that edge, leaving the sweep running.
   task automatic run_sweep(input int which, input bit hold, input int stop_at);
      int   sc, n, mode, exp_err, exp_ff, v;
      bit   exp_ffv;
      obs_t o;
      sc      = (which == 1) ? 1 : 3;
      mode    = (which == 1) ? mode1 : mode3;
      n       = 512 * (sc + 1);
      exp_err = 0;
      exp_ff  = 0;
      exp_ffv = 0;
      @(negedge clk);
      set_start(which, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) set_start(which, 1'b0);
      get_obs(which, o);
      check_eq("busy_rise", 32'(o.busy), 32'd1);
      check_eq("err_clear", 32'(o.err), 32'd0);
      for (int t = 1; t <= n; t++) begin
         @(posedge clk);
         #1;
         if (t % (sc + 1) == 0) begin
            v = t / (sc + 1) - 1;
            if (adder_model(mode, 9'(v)) != true_sum(9'(v))) begin
               exp_err++;
               if (!exp_ffv) begin
                  exp_ffv = 1;
                  exp_ff  = v;
               end
            end
         end
         get_obs(which, o);
         check_eq("busy", 32'(o.busy), 32'(t < n));
         check_eq("done", 32'(o.done), 32'(t == n));
         check_eq("vec",  32'(o.vec),  (t < n) ? 32'(t / (sc + 1)) : 32'd511);
         check_eq("err_count", 32'(o.err), 32'(exp_err));
         check_eq("first_fail_valid", 32'(o.ffv), 32'(exp_ffv));
         check_eq("first_fail", 32'(o.ff), 32'(exp_ff));
         if (t == n) check_eq("pass", 32'(o.pass), 32'(exp_err == 0));
         if (t == stop_at) return;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      obs_t o;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start1   = 1'b0;
      start3   = 1'b0;
      mode1    = 0;
      mode3    = 0;
      for (int i = 0; i < 512; i++)
         rand_mask[i] = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      rand_mask[$urandom_range(0, 99)] = 5'($urandom_range(1, 31));

      repeat (3) @(posedge clk);
      #1;
      check_reset_state(1, "rst1");
      check_reset_state(3, "rst3");
      @(negedge clk);
      rst = 1'b0;

      // Correct adder, SETTLE_CYCLES=1.
      run_sweep(1, 1'b0, -1);
      get_obs(1, o);
      check_eq("ok_pass", 32'(o.pass), 32'd1);

      // Carry stuck at zero (restart from DONE).
      mode1 = 1;
      run_sweep(1, 1'b0, -1);
      get_obs(1, o);
      check_eq("stuck_err", 32'(o.err), 32'd256);
      check_eq("stuck_ff",  32'(o.ff),  32'h01F);
      check_eq("stuck_pass", 32'(o.pass), 32'd0);

      // Single corrupted vector.
      mode1 = 2;
      run_sweep(1, 1'b0, -1);
      get_obs(1, o);
      check_eq("one_err", 32'(o.err), 32'd1);
      check_eq("one_ff",  32'(o.ff),  32'd300);
      check_eq("one_ffv", 32'(o.ffv), 32'd1);

      // start held high: one sweep, then immediate restart from DONE.
      mode1 = 1;
      run_sweep(1, 1'b1, -1);
      @(posedge clk);
      #1;
      get_obs(1, o);
      check_eq("restart_done", 32'(o.done), 32'd0);
      check_eq("restart_busy", 32'(o.busy), 32'd1);
      check_eq("restart_err",  32'(o.err),  32'd0);
      check_eq("restart_ffv",  32'(o.ffv),  32'd0);
      check_eq("restart_vec",  32'(o.vec),  32'd0);
      @(negedge clk);
      start1 = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state(1, "rst_after_hold");
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-sweep at idx=100, with start also high (reset wins).
      mode1 = 3;
      run_sweep(1, 1'b0, 201);
      @(negedge clk);
      rst    = 1'b1;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state(1, "rst_mid");
      @(negedge clk);
      rst    = 1'b0;
      start1 = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state(1, "idle_after_rst");
      run_sweep(1, 1'b0, -1);

      // SETTLE_CYCLES=3, correct adder.
      mode3 = 0;
      run_sweep(3, 1'b0, -1);
      get_obs(3, o);
      check_eq("s3_pass", 32'(o.pass), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
